bit_serializer: RTL and testbench



---
 rtl/serial_pkg.sv | 15 +
 rtl/bit_serializer.sv | 113 +++++++++++
 tb/tb_bit_serializer.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serializer and the downstream detector.
// One source of truth for state encoding and the detect pattern.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam logic [3:0] DETECT_PATTERN = 4'b1011;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: one WIDTH-bit word in over valid/ready,
// one bit per clock out with bit-valid, last-bit and busy flags.
module bit_serializer
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             bit_o,
  output logic             bit_valid_o,
  output logic             last_o,
  output logic             busy_o
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam bit HAS_GAP = (GAP_CYCLES != 0);
  localparam logic [7:0] GAP_LAST =
    HAS_GAP ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       gap_q, gap_d;

  logic in_shift;
  logic is_last;
  logic head_bit;
  logic accept;

  assign in_shift = (state_q == SHIFT);
  assign is_last  = in_shift && (cnt_q == CNT_LAST);
  assign head_bit = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];

  // Opening on the last bit lets the next word follow with no bubble.
  assign ready_o = !reset_i &&
                   ((state_q == IDLE) || (is_last && !HAS_GAP));
  assign accept  = valid_i && ready_o;

  assign bit_valid_o = in_shift;
  assign bit_o       = in_shift && head_bit;
  assign last_o      = is_last;
  assign busy_o      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d = data_i;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (is_last) begin
          cnt_d = '0;
          if (HAS_GAP) begin
            shift_d = '0;
            gap_d   = '0;
            state_d = GAP;
          end else if (accept) begin
            shift_d = data_i;
          end else begin
            shift_d = '0;
            state_d = IDLE;
          end
        end else begin
          cnt_d   = cnt_q + 1'b1;
          shift_d = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        shift_d = '0;
        cnt_d   = '0;
        gap_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench: three serializer configurations against
// a queue-of-bits reference model plus directed expectations.
module tb_bit_serializer;
  import serial_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] dat [3];
  logic       vld [3];
  logic       rdy [3];
  logic       bo  [3];
  logic       bv  [3];
  logic       lst [3];
  logic       bsy [3];

  int checks   = 0;
  int failures = 0;

  int          mcnt  [3];
  logic [63:0] mbits [3];
  int          mgap  [3];
  bit          macc  [3];

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u0 (
    .clk(clk), .reset_i(rst), .data_i(dat[0]), .valid_i(vld[0]),
    .ready_o(rdy[0]), .bit_o(bo[0]), .bit_valid_o(bv[0]),
    .last_o(lst[0]), .busy_o(bsy[0]));

  bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) u1 (
    .clk(clk), .reset_i(rst), .data_i(dat[1]), .valid_i(vld[1]),
    .ready_o(rdy[1]), .bit_o(bo[1]), .bit_valid_o(bv[1]),
    .last_o(lst[1]), .busy_o(bsy[1]));

  bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) u2 (
    .clk(clk), .reset_i(rst), .data_i(dat[2]), .valid_i(vld[2]),
    .ready_o(rdy[2]), .bit_o(bo[2]), .bit_valid_o(bv[2]),
    .last_o(lst[2]), .busy_o(bsy[2]));

  function automatic bit msb_of(int i);
    return i != 1;
  endfunction

  function automatic int gap_of(int i);
    return (i == 2) ? 2 : 0;
  endfunction

  // {ready, bit, bit_valid, last, busy}
  function automatic logic [4:0] exp_pack(int i);
    logic busy, ready, has;
    has   = mcnt[i] > 0;
    busy  = has || (mgap[i] > 0);
    ready = !rst &&
            (!busy || (mcnt[i] == 1 && gap_of(i) == 0));
    return {ready, has && mbits[i][0], has, mcnt[i] == 1, busy};
  endfunction

  function automatic logic [4:0] obs_pack(int i);
    return {rdy[i], bo[i], bv[i], lst[i], bsy[i]};
  endfunction

  task automatic model_update();
    logic [4:0] e;
    bit acc;
    for (int i = 0; i < 3; i++) begin
      e   = exp_pack(i);
      acc = vld[i] && e[4];
      if (rst) begin
        mcnt[i] = 0;
        mgap[i] = 0;
        macc[i] = 1'b0;
      end else begin
        macc[i] = acc;
        if (mcnt[i] > 0) begin
          mbits[i] = mbits[i] >> 1;
          mcnt[i]--;
          if (mcnt[i] == 0 && gap_of(i) > 0) mgap[i] = gap_of(i);
        end else if (mgap[i] > 0) begin
          mgap[i]--;
        end
        if (acc) begin
          for (int k = 0; k < 4; k++)
            mbits[i][mcnt[i] + k] =
              msb_of(i) ? dat[i][3 - k] : dat[i][k];
          mcnt[i] += 4;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0;
      dat[i] = 4'h0;
      mbits[i] = '0;
    end
    tick();
    tick();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_pack(i) !== 5'b00000) begin
        failures++;
        $display("FAIL reset_hold u%0d got=%b want=00000", i, obs_pack(i));
      end
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_pack(i) !== 5'b10000) begin
        failures++;
        $display("FAIL reset_release u%0d got=%b want=10000", i, obs_pack(i));
      end
    end
    tick();
  endtask

  task automatic test_msb_first();
    logic [7:0] coll = '0;
    int n = 0;
    dat[0] = DETECT_PATTERN;
    vld[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (macc[0]) vld[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (obs_pack(0) !== exp_pack(0)) begin
        failures++;
        $display("FAIL msb_cycle c=%0d got=%b want=%b", c, obs_pack(0), exp_pack(0));
      end
      if (bv[0]) begin
        coll = {coll[6:0], bo[0]};
        n++;
        checks++;
        if (lst[0] !== (n == 4) || (n == 4 && rdy[0] !== 1'b1)) begin
          failures++;
          $display("FAIL msb_last n=%0d last=%b ready=%b", n, lst[0], rdy[0]);
        end
      end
      tick();
    end
    checks++;
    if (n != 4 || coll[3:0] !== 4'b1011) begin
      failures++;
      $display("FAIL msb_stream got=%b n=%0d want=1011 n=4", coll[3:0], n);
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] coll = '0;
    int n = 0;
    dat[1] = 4'b0001;
    vld[1] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (macc[1]) vld[1] = 1'b0;
      @(negedge clk);
      checks++;
      if (obs_pack(1) !== exp_pack(1)) begin
        failures++;
        $display("FAIL lsb_cycle c=%0d got=%b want=%b", c, obs_pack(1), exp_pack(1));
      end
      if (bv[1]) begin
        coll = {coll[6:0], bo[1]};
        n++;
      end
      tick();
    end
    checks++;
    if (n != 4 || coll[3:0] !== 4'b1000) begin
      failures++;
      $display("FAIL lsb_stream got=%b n=%0d want=1000 n=4", coll[3:0], n);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] coll = '0;
    int n = 0, first = -1, last = -1, w = 0;
    dat[0] = 4'hA;
    vld[0] = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (macc[0]) begin
        w++;
        if (w == 1) dat[0] = 4'h5;
        else vld[0] = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (obs_pack(0) !== exp_pack(0)) begin
        failures++;
        $display("FAIL b2b_cycle c=%0d got=%b want=%b", c, obs_pack(0), exp_pack(0));
      end
      if (bv[0]) begin
        coll = {coll[6:0], bo[0]};
        n++;
        if (first < 0) first = c;
        last = c;
      end
      tick();
    end
    checks++;
    if (n != 8 || coll !== 8'b10100101 || last - first + 1 != 8) begin
      failures++;
      $display("FAIL b2b_stream got=%b n=%0d span=%0d want=10100101 n=8 span=8",
               coll, n, last - first + 1);
    end
  endtask

  task automatic test_gap();
    logic [7:0] coll = '0;
    int n = 0, low = 0, bgap = 0, rh = 0, w = 0;
    dat[2] = 4'h9;
    vld[2] = 1'b1;
    for (int c = 0; c < 18; c++) begin
      if (macc[2]) begin
        w++;
        if (w == 1) dat[2] = 4'h6;
        else vld[2] = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (obs_pack(2) !== exp_pack(2)) begin
        failures++;
        $display("FAIL gap_cycle c=%0d got=%b want=%b", c, obs_pack(2), exp_pack(2));
      end
      if (bv[2]) begin
        coll = {coll[6:0], bo[2]};
        n++;
      end else if (n == 4) begin
        low++;
        if (bsy[2]) bgap++;
        if (rdy[2]) rh++;
      end
      tick();
    end
    checks++;
    if (n != 8 || coll !== 8'b10010110) begin
      failures++;
      $display("FAIL gap_stream got=%b n=%0d want=10010110 n=8", coll, n);
    end
    checks++;
    if (bgap != 2 || low != 3 || rh != 1) begin
      failures++;
      $display("FAIL gap_timing busy=%0d idle=%0d ready=%0d want busy=2 idle=3 ready=1",
               bgap, low, rh);
    end
  endtask

  task automatic test_ignore();
    logic [7:0] coll = '0;
    int n = 0, k = 0;
    bit ph = 1'b0;
    dat[0] = DETECT_PATTERN;
    vld[0] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (macc[0] && !ph) begin
        vld[0] = 1'b0;
        ph = 1'b1;
      end
      if (ph) begin
        k++;
        if (k == 2) begin
          dat[0] = 4'hF;
          vld[0] = 1'b1;
        end
        if (k == 4) vld[0] = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (obs_pack(0) !== exp_pack(0)) begin
        failures++;
        $display("FAIL ignore_cycle c=%0d got=%b want=%b", c, obs_pack(0), exp_pack(0));
      end
      if (bv[0]) begin
        coll = {coll[6:0], bo[0]};
        n++;
      end
      tick();
    end
    checks++;
    if (n != 4 || coll[3:0] !== 4'b1011) begin
      failures++;
      $display("FAIL ignore_stream got=%b n=%0d want=1011 n=4", coll[3:0], n);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bit pulsed = 1'b0, after = 1'b0;
    dat[0] = DETECT_PATTERN;
    vld[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (macc[0]) vld[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (obs_pack(0) !== exp_pack(0)) begin
        failures++;
        $display("FAIL rstmid_cycle c=%0d got=%b want=%b", c, obs_pack(0), exp_pack(0));
      end
      if (after) begin
        after = 1'b0;
        checks++;
        if (obs_pack(0) !== 5'b10000) begin
          failures++;
          $display("FAIL rstmid_after got=%b want=10000", obs_pack(0));
        end
      end
      if (bv[0]) n++;
      if (n == 2 && !pulsed) begin
        rst = 1'b1;
        pulsed = 1'b1;
      end
      tick();
      if (rst) begin
        rst = 1'b0;
        after = 1'b1;
      end
    end
    checks++;
    if (n != 2) begin
      failures++;
      $display("FAIL rstmid_bits got=%0d want=2", n);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!vld[i] || macc[i]) begin
          vld[i] = 1'($urandom_range(0, 1));
          dat[i] = 4'($urandom);
        end
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_pack(i) !== exp_pack(i)) begin
          failures++;
          $display("FAIL random u%0d c=%0d got=%b want=%b",
                   i, c, obs_pack(i), exp_pack(i));
        end
      end
      tick();
    end
    for (int i = 0; i < 3; i++) vld[i] = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mcnt[i] = 0;
      mgap[i] = 0;
      macc[i] = 1'b0;
      mbits[i] = '0;
    end
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_gap();
    test_ignore();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
